// File: rtl/spi_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_tx
//  Brief    : Snapshots a 160-bit measurement word and sends it as one framed
//             SPI (mode 0) burst: 0x55, 0xAA, 20 payload bytes, checksum.
//  Revision : 1.0  initial release
// ============================================================================
module spi_frame_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         frame_start,
    input  logic [159:0] payload,
    output logic         busy,
    output logic         frame_done,
    output logic         sck,
    output logic         miso,
    output logic         cs
);

    localparam int c_CNT_MAX = (2 * CLK_DIV > GAP_CYCLES) ? 2 * CLK_DIV : GAP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_DIV      = c_CNT_W'(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(2 * CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [4:0]         c_LAST_BYTE = 5'd22;
    localparam logic [4:0]         c_LAST_PAY  = 5'd21;
    localparam logic [7:0]         c_SYNC0     = 8'h55;
    localparam logic [7:0]         c_SYNC1     = 8'hAA;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_GAP   = 3'd3,
        S_TRAIL = 3'd4
    } state_t;

    state_t               r_state,    w_state;
    logic [c_CNT_W-1:0]   r_cnt,      w_cnt;
    logic [2:0]           r_bit,      w_bit;
    logic [4:0]           r_byte_idx, w_byte_idx;
    logic [7:0]           r_shift,    w_shift;
    logic [159:0]         r_pay,      w_pay;
    logic [7:0]           r_csum,     w_csum;
    logic                 r_busy,     w_busy;
    logic                 r_done,     w_done;
    logic                 r_sck,      w_sck;
    logic                 r_miso,     w_miso;
    logic                 r_cs,       w_cs;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_pay      <= '0;
            r_csum     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sck      <= 1'b0;
            r_miso     <= 1'b0;
            r_cs       <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_bit      <= w_bit;
            r_byte_idx <= w_byte_idx;
            r_shift    <= w_shift;
            r_pay      <= w_pay;
            r_csum     <= w_csum;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_sck      <= w_sck;
            r_miso     <= w_miso;
            r_cs       <= w_cs;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_bit      = r_bit;
        w_byte_idx = r_byte_idx;
        w_shift    = r_shift;
        w_pay      = r_pay;
        w_csum     = r_csum;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_miso     = r_miso;
        w_cs       = r_cs;

        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state    = S_LEAD;
                    w_cnt      = '0;
                    w_bit      = '0;
                    w_byte_idx = '0;
                    w_shift    = c_SYNC0;
                    w_pay      = payload;
                    w_csum     = '0;
                    w_busy     = 1'b1;
                    w_cs       = 1'b0;
                    w_miso     = c_SYNC0[7];
                end
            end
            S_LEAD: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_state = S_SHIFT;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt != c_BIT_LAST) begin
                    w_cnt = r_cnt + 1'b1;
                end else begin
                    w_cnt = '0;
                    if (r_bit != 3'd7) begin
                        w_bit   = r_bit + 3'd1;
                        w_shift = {r_shift[6:0], 1'b0};
                        w_miso  = r_shift[6];
                    end else if (r_byte_idx == c_LAST_BYTE) begin
                        w_state = S_TRAIL;
                        w_miso  = 1'b0;
                    end else begin
                        w_state    = (GAP_CYCLES > 0) ? S_GAP : S_SHIFT;
                        w_bit      = '0;
                        w_byte_idx = r_byte_idx + 5'd1;
                        // Payload bytes stream out of the top of the latched copy;
                        // the running sum is complete once byte 21 has been loaded.
                        if (r_byte_idx == 5'd0) begin
                            w_shift = c_SYNC1;
                        end else if (r_byte_idx == c_LAST_PAY) begin
                            w_shift = r_csum;
                        end else begin
                            w_shift = r_pay[159:152];
                            w_pay   = {r_pay[151:0], 8'h00};
                            w_csum  = r_csum + r_pay[159:152];
                        end
                        w_miso = w_shift[7];
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_state = S_SHIFT;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_TRAIL: begin
                if (r_cnt == c_DIV_LAST) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_cs    = 1'b1;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // sck is high in the second half of every bit period only
        w_sck = (w_state == S_SHIFT) && (w_cnt >= c_DIV);
    end

    assign busy       = r_busy;
    assign frame_done = r_done;
    assign sck        = r_sck;
    assign miso       = r_miso;
    assign cs         = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_frame_tx
//  Brief    : Scoreboard bench; two instances (CLK_DIV=2/GAP=4, CLK_DIV=1/GAP=0)
//             with a shared byte monitor on the selected instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_frame_tx;

    logic         clk;
    logic         rst_a, rst_b;
    logic         st_a, st_b;
    logic [159:0] pay_a, pay_b;
    logic         busy_a, busy_b, dn_a, dn_b, sck_a, sck_b, miso_a, miso_b, cs_a, cs_b;

    logic         ch;
    logic         m_rst, m_sck, m_miso, m_cs, m_done, m_busy;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [7:0]   exp_q[$];

    int           len = 0;
    int           nbits = 0;
    int           nbytes = 0;
    int           done_cnt = 0;
    logic [7:0]   sh = 8'h00;
    logic         prev_sck = 1'b0;
    logic         prev_cs = 1'b1;

    localparam logic [159:0] c_P_ZERO = '0;
    localparam logic [159:0] c_P_ONES = {20{8'h01}};
    localparam logic [159:0] c_P_FF   = {20{8'hFF}};
    localparam logic [159:0] c_P_INC  = 160'h0102030405060708090A0B0C0D0E0F1011121314;
    localparam logic [159:0] c_P_ALT  = {10{16'hA55A}};

    spi_frame_tx #(.CLK_DIV(2), .GAP_CYCLES(4)) dut_a (
        .sys_clk     (clk),
        .rst         (rst_a),
        .frame_start (st_a),
        .payload     (pay_a),
        .busy        (busy_a),
        .frame_done  (dn_a),
        .sck         (sck_a),
        .miso        (miso_a),
        .cs          (cs_a)
    );

    spi_frame_tx #(.CLK_DIV(1), .GAP_CYCLES(0)) dut_b (
        .sys_clk     (clk),
        .rst         (rst_b),
        .frame_start (st_b),
        .payload     (pay_b),
        .busy        (busy_b),
        .frame_done  (dn_b),
        .sck         (sck_b),
        .miso        (miso_b),
        .cs          (cs_b)
    );

    assign m_rst  = ch ? rst_b  : rst_a;
    assign m_sck  = ch ? sck_b  : sck_a;
    assign m_miso = ch ? miso_b : miso_a;
    assign m_cs   = ch ? cs_b   : cs_a;
    assign m_done = ch ? dn_b   : dn_a;
    assign m_busy = ch ? busy_b : busy_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: bytes sampled on sck rising edges, frame closed on cs rising edge
    always @(negedge clk) begin
        if (m_rst) begin
            len = 0; nbits = 0; nbytes = 0; sh = 8'h00;
            prev_sck = m_sck; prev_cs = m_cs;
        end else begin
            if (!m_cs) len++;
            if (m_sck && !prev_sck) begin
                sh = {sh[6:0], m_miso};
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL byte_unexpected actual=%0h required=none", sh);
                    end else begin
                        check($sformatf("byte%0d", nbytes), 32'(sh), 32'(exp_q.pop_front()));
                    end
                    nbytes++;
                end
            end
            if (m_cs && !prev_cs) begin
                check("cs_low_cycles", 32'(len), ch ? 32'd370 : 32'd828);
                check("bytes_in_frame", 32'(nbytes), 32'd23);
                check("done_on_cs_rise", 32'(m_done), 32'd1);
                len = 0; nbytes = 0; nbits = 0;
            end
            if (m_done) done_cnt++;
            prev_sck = m_sck;
            prev_cs  = m_cs;
        end
    end

    task automatic push_exp(input logic [159:0] p, input logic [7:0] csum);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        for (int k = 0; k < 20; k++) exp_q.push_back(p[159 - 8 * k -: 8]);
        exp_q.push_back(csum);
    endtask

    // Called at a negedge; the following posedge samples frame_start
    task automatic pulse_start(input logic [159:0] p);
        if (ch) begin pay_b = p; st_b = 1'b1; end
        else    begin pay_a = p; st_a = 1'b1; end
        @(negedge clk);
        st_a = 1'b0;
        st_b = 1'b0;
    endtask

    task automatic start_frame(input logic [159:0] p, input logic [7:0] csum);
        int i;
        for (i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!m_busy) break;
        end
        check("idle_before_start", 32'(i < 4000), 32'd1);
        push_exp(p, csum);
        pulse_start(p);
    endtask

    task automatic wait_done(input int target);
        int i;
        for (i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done_cnt >= target) break;
        end
        check("frame_done_count", 32'(done_cnt), 32'(target));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        ch = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        st_a = 1'b0; st_b = 1'b0;
        pay_a = '0; pay_b = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_a",   32'(cs_a),   32'd1);
        check("rst_sck_a",  32'(sck_a),  32'd0);
        check("rst_miso_a", 32'(miso_a), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(dn_a),   32'd0);
        check("rst_cs_b",   32'(cs_b),   32'd1);
        check("rst_sck_b",  32'(sck_b),  32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(negedge clk);

        // T1: zero payload, 828-cycle frame
        start_frame(c_P_ZERO, 8'h00);
        check("busy_after_accept", 32'(busy_a), 32'd1);
        wait_done(1);

        // T2: checksum vectors
        start_frame(c_P_ONES, 8'h14);
        wait_done(2);
        start_frame(c_P_FF, 8'hEC);
        wait_done(3);

        // T3: incrementing bytes; live payload disturbed mid-frame
        start_frame(c_P_INC, 8'hD2);
        repeat (200) @(negedge clk);
        pay_a = ~c_P_INC;
        wait_done(4);

        // T4: start while busy is ignored
        start_frame(c_P_ALT, 8'hF6);
        repeat (99) @(negedge clk);
        check("busy_mid_frame", 32'(busy_a), 32'd1);
        pulse_start(c_P_FF);
        wait_done(5);
        repeat (900) @(negedge clk);
        check("no_queued_frame", 32'(done_cnt), 32'd5);
        check("cs_idle_after", 32'(cs_a), 32'd1);

        // T5: asynchronous reset at byte 10
        start_frame(c_P_INC, 8'hD2);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (nbytes >= 10) break;
        end
        check("reached_byte10", 32'(nbytes >= 10), 32'd1);
        #2 rst_a = 1'b1;
        #1;
        check("abort_cs",   32'(cs_a),   32'd1);
        check("abort_sck",  32'(sck_a),  32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(dn_a),   32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        repeat (2) @(negedge clk);
        check("no_done_on_abort", 32'(done_cnt), 32'd5);
        start_frame(c_P_ALT, 8'hF6);
        wait_done(6);

        // T6: CLK_DIV=1, GAP=0, back-to-back on the frame_done cycle
        ch = 1'b1;
        repeat (2) @(negedge clk);
        start_frame(c_P_INC, 8'hD2);
        begin
            int i;
            for (i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (dn_b) break;
            end
            check("b2b_done_seen", 32'(i < 1000), 32'd1);
        end
        push_exp(c_P_ONES, 8'h14);
        pulse_start(c_P_ONES);
        check("b2b_cs_low", 32'(cs_b), 32'd0);
        check("b2b_busy",   32'(busy_b), 32'd1);
        wait_done(8);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
